// File: rtl/alu_uart_frontend_if.sv
// Bus bundle between the UART rx/tx pair, the ALU and the byte-stream front end.
// The "master" side is the front end itself; the "slave" side is its environment
// (UART receiver/transmitter and the ALU).
interface alu_uart_frontend_if #(
   parameter int N_BITS  = 32,
   parameter int NB_BYTE = 8,
   parameter int NB_OP   = 6
);
   // Inputs to the front end
   logic [NB_BYTE-1:0] i_rx_data;
   logic               i_rx_done;
   logic               i_tx_done;
   logic [N_BITS-1:0]  i_alu_result;

   // Outputs from the front end
   logic [N_BITS-1:0]  o_alu_a;
   logic [N_BITS-1:0]  o_alu_b;
   logic [NB_OP-1:0]   o_alu_op;
   logic [NB_BYTE-1:0] o_tx_data;
   logic               o_tx_start;
   logic               o_busy;

   modport master (
      input  i_rx_data, i_rx_done, i_tx_done, i_alu_result,
      output o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy
   );

   modport slave (
      output i_rx_data, i_rx_done, i_tx_done, i_alu_result,
      input  o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy
   );
endinterface

// File: rtl/alu_uart_frontend.sv
// Byte-stream front end for ALU bring-up over UART.
// Collects operand A, operand B (little-endian, NBYTES bytes each) and an
// operation byte, presents them to the ALU, latches the result and streams it
// back byte by byte over a start/done handshake with the transmitter.
// N_BITS must be a multiple of NB_BYTE.
module alu_uart_frontend #(
   parameter int N_BITS  = 32,
   parameter int NB_BYTE = 8,
   parameter int NB_OP   = 6
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   alu_uart_frontend_if.master   bus
);

   localparam int NBYTES = N_BITS / NB_BYTE;
   localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);

   typedef enum logic [2:0] {
      RX_A     = 3'd0,
      RX_B     = 3'd1,
      RX_OP    = 3'd2,
      EXEC     = 3'd3,
      TX_START = 3'd4,
      TX_WAIT  = 3'd5
   } state_t;

   state_t             state_q,   state_d;
   logic [CNT_W-1:0]   cnt_q,     cnt_d;
   logic [N_BITS-1:0]  alu_a_q,   alu_a_d;
   logic [N_BITS-1:0]  alu_b_q,   alu_b_d;
   logic [NB_OP-1:0]   alu_op_q,  alu_op_d;
   logic [N_BITS-1:0]  result_q,  result_d;
   logic [NB_BYTE-1:0] tx_data_q, tx_data_d;

   logic [CNT_W-1:0]   cnt_inc;
   logic               cnt_last;

   assign cnt_inc  = cnt_q + CNT_W'(1);
   assign cnt_last = (cnt_q == CNT_LAST);

   // State and datapath registers; synchronous reset dominates every input.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q   <= RX_A;
         cnt_q     <= '0;
         alu_a_q   <= '0;
         alu_b_q   <= '0;
         alu_op_q  <= '0;
         result_q  <= '0;
         tx_data_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         alu_a_q   <= alu_a_d;
         alu_b_q   <= alu_b_d;
         alu_op_q  <= alu_op_d;
         result_q  <= result_d;
         tx_data_q <= tx_data_d;
      end
   end

   // Next-state and datapath update; every register holds unless its state acts.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      alu_a_d   = alu_a_q;
      alu_b_d   = alu_b_q;
      alu_op_d  = alu_op_q;
      result_d  = result_q;
      tx_data_d = tx_data_q;

      case (state_q)
         RX_A: begin
            if (bus.i_rx_done) begin
               alu_a_d[int'(cnt_q)*NB_BYTE +: NB_BYTE] = bus.i_rx_data;
               if (cnt_last) begin
                  cnt_d   = '0;
                  state_d = RX_B;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end

         RX_B: begin
            if (bus.i_rx_done) begin
               alu_b_d[int'(cnt_q)*NB_BYTE +: NB_BYTE] = bus.i_rx_data;
               if (cnt_last) begin
                  cnt_d   = '0;
                  state_d = RX_OP;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end

         RX_OP: begin
            if (bus.i_rx_done) begin
               alu_op_d = bus.i_rx_data[NB_OP-1:0];
               state_d  = EXEC;
            end
         end

         // The tx byte is registered on entry to TX_START so it stays stable
         // until the next TX_START; byte 0 comes straight from the ALU here
         // because result_q is only being loaded on this same edge.
         EXEC: begin
            result_d  = bus.i_alu_result;
            tx_data_d = bus.i_alu_result[NB_BYTE-1:0];
            cnt_d     = '0;
            state_d   = TX_START;
         end

         TX_START: begin
            state_d = TX_WAIT;
         end

         TX_WAIT: begin
            if (bus.i_tx_done) begin
               if (cnt_last) begin
                  cnt_d   = '0;
                  state_d = RX_A;
               end else begin
                  cnt_d     = cnt_inc;
                  tx_data_d = result_q[int'(cnt_inc)*NB_BYTE +: NB_BYTE];
                  state_d   = TX_START;
               end
            end
         end

         default: begin
            state_d = RX_A;
         end
      endcase
   end

   assign bus.o_alu_a    = alu_a_q;
   assign bus.o_alu_b    = alu_b_q;
   assign bus.o_alu_op   = alu_op_q;
   assign bus.o_tx_data  = tx_data_q;
   assign bus.o_tx_start = (state_q == TX_START);
   assign bus.o_busy     = (state_q == EXEC) || (state_q == TX_START) || (state_q == TX_WAIT);

endmodule

// File: tb/tb_alu_uart_frontend.sv
// Self-checking bench for alu_uart_frontend: directed frames from the bring-up
// plan plus randomized frames checked against a behavioural ALU/byte model.
module tb_alu_uart_frontend;

   localparam int N_BITS   = 32;
   localparam int NB_BYTE  = 8;
   localparam int NB_OP    = 6;
   localparam int NBYTES   = N_BITS / NB_BYTE;
   localparam int TX_DELAY = 5;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   alu_uart_frontend_if #(.N_BITS(N_BITS), .NB_BYTE(NB_BYTE), .NB_OP(NB_OP)) bus ();

   alu_uart_frontend #(.N_BITS(N_BITS), .NB_BYTE(NB_BYTE), .NB_OP(NB_OP)) dut (
      .i_clk   (clk),
      .i_reset (reset),
      .bus     (bus)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Bytes seen on the transmitter side and the cycle each start was seen.
   logic [7:0] txq[$];
   int         txc[$];

   // Behavioural ALU: unknown op codes give zero.
   function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic [5:0] op);
      case (op)
         6'h20:   return a + b;
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h26:   return a ^ b;
         6'h27:   return ~(a | b);
         6'h02:   return a >> b[4:0];
         6'h03:   return 32'($signed(a) >>> b[4:0]);
         6'h2a:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   // Stand-in for the ALU wired to the front end's operand/op outputs.
   always_comb bus.i_alu_result = alu_ref(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);

   // Transmitter model: records each started byte, answers with i_tx_done
   // TX_DELAY cycles after each start.
   initial begin : tx_side
      int cd;
      cd = 0;
      bus.i_tx_done = 1'b0;
      forever begin
         @(negedge clk);
         bus.i_tx_done = 1'b0;
         if (cd > 0) begin
            cd--;
            if (cd == 0) bus.i_tx_done = 1'b1;
         end
         if (bus.o_tx_start === 1'b1) begin
            txq.push_back(bus.o_tx_data);
            txc.push_back(cyc);
            cd = TX_DELAY;
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.i_rx_data = b;
      bus.i_rx_done = 1'b1;
      @(negedge clk);
      bus.i_rx_done = 1'b0;
   endtask

   task automatic send_bytes(input logic [31:0] w, input int from, input bit gaps);
      for (int i = from; i < NBYTES; i++) begin
         send_byte(w[8*i +: 8]);
         if (gaps) idle($urandom_range(0, 2));
      end
   endtask

   // Sends A (from byte a_from), B and the op byte, then follows the busy period.
   // Optionally pulses a stray rx byte 0xAA while the front end is busy.
   task automatic run_frame(input logic [31:0] a, input logic [31:0] b, input logic [7:0] opb,
                            input int a_from, input bit gaps, input bit inject,
                            output int lat, output int busy_cyc,
                            output logic [31:0] word, output int ntx);
      int c_op;
      txq.delete();
      txc.delete();
      send_bytes(a, a_from, gaps);
      send_bytes(b, 0, gaps);
      c_op = cyc;
      send_byte(opb);
      busy_cyc = 0;
      while (bus.o_busy === 1'b1 && busy_cyc < 400) begin
         busy_cyc++;
         bus.i_rx_data = 8'hAA;
         bus.i_rx_done = inject && (busy_cyc == 4);
         @(negedge clk);
      end
      bus.i_rx_done = 1'b0;
      ntx  = txq.size();
      word = '0;
      for (int i = 0; i < ntx && i < NBYTES; i++) word[8*i +: 8] = txq[i];
      lat = (ntx > 0) ? (txc[0] - c_op) : -1;
   endtask

   task automatic test_reset();
      bus.i_rx_data = 8'h5A;
      bus.i_rx_done = 1'b1;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (bus.o_alu_a !== 32'h0) begin failures++; $display("FAIL reset_alu_a: got %h expected %h", bus.o_alu_a, 32'h0); end
      checks++; if (bus.o_alu_b !== 32'h0) begin failures++; $display("FAIL reset_alu_b: got %h expected %h", bus.o_alu_b, 32'h0); end
      checks++; if (bus.o_alu_op !== 6'h0) begin failures++; $display("FAIL reset_alu_op: got %h expected %h", bus.o_alu_op, 6'h0); end
      checks++; if (bus.o_tx_data !== 8'h0) begin failures++; $display("FAIL reset_tx_data: got %h expected %h", bus.o_tx_data, 8'h0); end
      checks++; if (bus.o_tx_start !== 1'b0) begin failures++; $display("FAIL reset_tx_start: got %b expected 0", bus.o_tx_start); end
      checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.o_busy); end
      reset = 1'b0;
      bus.i_rx_done = 1'b0;
      idle(2);
   endtask

   task automatic test_add();
      int lat, bc, ntx; logic [31:0] w;
      run_frame(32'd5, 32'd3, 8'h20, 0, 1'b0, 1'b0, lat, bc, w, ntx);
      checks++; if (w !== 32'h0000_0008) begin failures++; $display("FAIL add_result: got %h expected %h", w, 32'h8); end
      checks++; if (ntx !== NBYTES) begin failures++; $display("FAIL add_ntx: got %0d expected %0d", ntx, NBYTES); end
      checks++; if (bus.o_alu_op !== 6'h20) begin failures++; $display("FAIL add_op: got %h expected 20", bus.o_alu_op); end
      checks++; if (lat !== 2) begin failures++; $display("FAIL add_latency: got %0d expected 2", lat); end
      checks++; if (bus.o_alu_a !== 32'd5) begin failures++; $display("FAIL add_alu_a: got %h expected 5", bus.o_alu_a); end
      checks++; if (bus.o_alu_b !== 32'd3) begin failures++; $display("FAIL add_alu_b: got %h expected 3", bus.o_alu_b); end
   endtask

   task automatic test_sub_busy();
      int lat, bc, ntx; logic [31:0] w;
      run_frame(32'd3, 32'd5, 8'h22, 0, 1'b1, 1'b0, lat, bc, w, ntx);
      checks++; if (w !== 32'hFFFF_FFFE) begin failures++; $display("FAIL sub_result: got %h expected %h", w, 32'hFFFF_FFFE); end
      // EXEC, then per byte one TX_START cycle plus TX_DELAY cycles of waiting.
      checks++; if (bc !== 1 + NBYTES*(1 + TX_DELAY)) begin failures++; $display("FAIL sub_busy_cycles: got %0d expected %0d", bc, 1 + NBYTES*(1 + TX_DELAY)); end
   endtask

   task automatic test_shift();
      int lat, bc, ntx; logic [31:0] w;
      run_frame(32'h8000_0000, 32'd4, 8'h03, 0, 1'b0, 1'b0, lat, bc, w, ntx);
      checks++; if (w !== 32'hF800_0000) begin failures++; $display("FAIL sra_result: got %h expected %h", w, 32'hF800_0000); end
      run_frame(32'h8000_0000, 32'd4, 8'h02, 0, 1'b0, 1'b0, lat, bc, w, ntx);
      checks++; if (w !== 32'h0800_0000) begin failures++; $display("FAIL srl_result: got %h expected %h", w, 32'h0800_0000); end
   endtask

   task automatic test_op_upper();
      int lat, bc, ntx; logic [31:0] w;
      run_frame(32'hFF00_FF00, 32'h0FF0_0FF0, 8'hE4, 0, 1'b0, 1'b0, lat, bc, w, ntx);
      checks++; if (bus.o_alu_op !== 6'h24) begin failures++; $display("FAIL opupper_op: got %h expected 24", bus.o_alu_op); end
      checks++; if (w !== 32'h0F00_0F00) begin failures++; $display("FAIL opupper_result: got %h expected %h", w, 32'h0F00_0F00); end
   endtask

   // Follows test_op_upper: A=FF00FF00, B=0FF00FF0 are still held.
   task automatic test_hold();
      int lat, bc, ntx; logic [31:0] w;
      send_byte(8'h11);
      send_byte(8'h22);
      checks++; if (bus.o_alu_a !== 32'hFF00_2211) begin failures++; $display("FAIL hold_partial_a: got %h expected %h", bus.o_alu_a, 32'hFF00_2211); end
      checks++; if (bus.o_alu_b !== 32'h0FF0_0FF0) begin failures++; $display("FAIL hold_b: got %h expected %h", bus.o_alu_b, 32'h0FF0_0FF0); end
      run_frame(32'h4433_2211, 32'h10, 8'h20, 2, 1'b0, 1'b0, lat, bc, w, ntx);
      checks++; if (w !== 32'h4433_2221) begin failures++; $display("FAIL hold_result: got %h expected %h", w, 32'h4433_2221); end
   endtask

   task automatic test_busy_drop();
      int lat, bc, ntx; logic [31:0] w;
      run_frame(32'd7, 32'd9, 8'h20, 0, 1'b0, 1'b1, lat, bc, w, ntx);
      checks++; if (w !== 32'd16) begin failures++; $display("FAIL drop_result: got %h expected %h", w, 32'd16); end
      checks++; if (bus.o_alu_a !== 32'd7) begin failures++; $display("FAIL drop_alu_a: got %h expected 7", bus.o_alu_a); end
      run_frame(32'd1, 32'd1, 8'h20, 0, 1'b0, 1'b0, lat, bc, w, ntx);
      checks++; if (w !== 32'h0000_0002) begin failures++; $display("FAIL drop_next_result: got %h expected 2", w); end
      checks++; if (bus.o_alu_b !== 32'd1) begin failures++; $display("FAIL drop_next_b: got %h expected 1", bus.o_alu_b); end
   endtask

   task automatic test_reset_midframe();
      int lat, bc, ntx; logic [31:0] w;
      for (int i = 1; i <= 5; i++) send_byte(8'(i));
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++; if (bus.o_alu_a !== 32'h0) begin failures++; $display("FAIL rstmid_alu_a: got %h expected 0", bus.o_alu_a); end
      checks++; if (bus.o_alu_b !== 32'h0) begin failures++; $display("FAIL rstmid_alu_b: got %h expected 0", bus.o_alu_b); end
      checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", bus.o_busy); end
      run_frame(32'hFFFF_FFFF, 32'h0000_FFFF, 8'h26, 0, 1'b0, 1'b0, lat, bc, w, ntx);
      checks++; if (w !== 32'hFFFF_0000) begin failures++; $display("FAIL rstmid_xor_result: got %h expected %h", w, 32'hFFFF_0000); end
      checks++; if (ntx !== NBYTES) begin failures++; $display("FAIL rstmid_ntx: got %0d expected %0d", ntx, NBYTES); end
   endtask

   task automatic test_reset_tx();
      int g;
      int seen;
      txq.delete();
      txc.delete();
      send_bytes(32'h1234_5678, 0, 1'b0);
      send_bytes(32'd1, 0, 1'b0);
      send_byte(8'h20);
      g = 0;
      while (txq.size() == 0 && g < 30) begin
         g++;
         @(negedge clk);
      end
      seen = txq.size();
      checks++; if (seen !== 1) begin failures++; $display("FAIL rsttx_first_start: got %0d starts expected 1", seen); end
      idle(2);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++; if (bus.o_busy !== 1'b0) begin failures++; $display("FAIL rsttx_busy: got %b expected 0", bus.o_busy); end
      checks++; if (bus.o_tx_data !== 8'h0) begin failures++; $display("FAIL rsttx_tx_data: got %h expected 0", bus.o_tx_data); end
      txq.delete();
      txc.delete();
      idle(40);
      checks++; if (txq.size() !== 0) begin failures++; $display("FAIL rsttx_no_more_starts: got %0d expected 0", txq.size()); end
   endtask

   task automatic test_random();
      logic [5:0] ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h02, 6'h03};
      int lat, bc, ntx; logic [31:0] w, a, b, exp; logic [7:0] opb;
      for (int n = 0; n < 25; n++) begin
         a = $urandom();
         b = $urandom();
         if ($urandom_range(0, 7) == 0) opb = 8'($urandom());
         else opb = {2'($urandom()), ops[$urandom_range(0, 7)]};
         run_frame(a, b, opb, 0, 1'b1, 1'($urandom_range(0, 1)), lat, bc, w, ntx);
         exp = alu_ref(a, b, opb[5:0]);
         checks++; if (w !== exp) begin failures++; $display("FAIL rand_result[%0d]: got %h expected %h (op %h)", n, w, exp, opb); end
         checks++; if (ntx !== NBYTES) begin failures++; $display("FAIL rand_ntx[%0d]: got %0d expected %0d", n, ntx, NBYTES); end
         checks++; if (lat !== 2) begin failures++; $display("FAIL rand_latency[%0d]: got %0d expected 2", n, lat); end
         checks++; if (bus.o_alu_op !== opb[5:0]) begin failures++; $display("FAIL rand_op[%0d]: got %h expected %h", n, bus.o_alu_op, opb[5:0]); end
         checks++; if (bus.o_alu_a !== a) begin failures++; $display("FAIL rand_alu_a[%0d]: got %h expected %h", n, bus.o_alu_a, a); end
         checks++; if (bus.o_alu_b !== b) begin failures++; $display("FAIL rand_alu_b[%0d]: got %h expected %h", n, bus.o_alu_b, b); end
      end
   endtask

   initial begin : main
      bus.i_rx_data = 8'h00;
      bus.i_rx_done = 1'b0;
      @(negedge clk);
      test_reset();
      test_add();
      test_sub_busy();
      test_shift();
      test_op_upper();
      test_hold();
      test_busy_drop();
      test_reset_midframe();
      test_reset_tx();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_uart_frontend.md
Name: alu_uart_frontend

Overview:
- Byte-stream front end for the ALU, used for board-level ALU bring-up over UART.
- Collects operand A, operand B and an operation byte from a UART receiver, drives them to the ALU, and latches the result.
- Returns the result byte-by-byte to a UART transmitter over a start/done handshake.
- Sits between the UART rx/tx pair and the ALU's operand and operation inputs.

Parameters:
- N_BITS, 32, ALU operand/result width. Must be a multiple of NB_BYTE.
- NB_BYTE, 8, UART data width.
- NB_OP, 6, ALU operation code width.

Ports:
- i_clk  in  1  system clock; all logic on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_rx_data  in  NB_BYTE  received byte; valid while i_rx_done=1.
- i_rx_done  in  1  one-cycle pulse: new byte on i_rx_data.
- i_tx_done  in  1  one-cycle pulse: transmitter finished the current byte.
- i_alu_result  in  N_BITS  ALU output (combinational from o_alu_a/o_alu_b/o_alu_op).
- o_alu_a  out  N_BITS  registered operand A.
- o_alu_b  out  N_BITS  registered operand B.
- o_alu_op  out  NB_OP  registered operation code.
- o_tx_data  out  NB_BYTE  byte for the transmitter.
- o_tx_start  out  1  one-cycle pulse: transmit o_tx_data.
- o_busy  out  1  high while executing or transmitting; rx bytes are dropped.

Behaviour:
- Reset (sync, active-high, dominant over all other inputs):
  - o_alu_a, o_alu_b, o_alu_op, o_tx_data, result register and byte counter clear to 0.
  - o_tx_start=0, o_busy=0, state=RX_A.
  - Reset mid-frame or mid-transmit discards all partial data; no further tx pulses are issued.
- Byte order: little-endian. The first received byte of an operand is bits [7:0]. NBYTES = N_BITS/NB_BYTE.
- RX_A:
  - On each i_rx_done, write i_rx_data into byte[cnt] of o_alu_a and increment cnt.
  - On the NBYTES-th byte, clear cnt and go to RX_B.
  - Bytes not yet written hold their previous value.
- RX_B: same as RX_A, for o_alu_b. On the last byte go to RX_OP.
- RX_OP:
  - On i_rx_done, o_alu_op <= i_rx_data[NB_OP-1:0]; upper bits are ignored.
  - Go to EXEC.
- EXEC (exactly 1 cycle):
  - Operands and op have been stable since the previous edge.
  - result <= i_alu_result; cnt <= 0; go to TX_START.
  - o_busy=1 from EXEC through TX_WAIT inclusive.
- TX_START (1 cycle):
  - o_tx_start=1; o_tx_data=result byte[cnt], held stable until the next TX_START.
  - Go to TX_WAIT.
- TX_WAIT:
  - Wait for i_tx_done, then increment cnt.
  - If cnt was NBYTES-1: clear cnt, go to RX_A, o_busy drops.
  - Otherwise: go to TX_START.
- Latency:
  - Op byte's i_rx_done sampled at edge t → EXEC during cycle t+1.
  - First o_tx_start high during cycle t+2.
  - Each subsequent o_tx_start is 1 cycle after the i_tx_done that completes the previous byte.
- i_rx_done in EXEC/TX_START/TX_WAIT: ignored; byte dropped, no state change.
- i_tx_done outside TX_WAIT: ignored.
- i_rx_done and i_tx_done in the same cycle: each is handled only by its owning state; no conflict.
- o_alu_a, o_alu_b and o_alu_op retain the last frame's values until overwritten byte-by-byte by the next frame.
- Unsupported op codes: the ALU result is undefined. The block still latches it and transmits NBYTES bytes; no error flag.
- i_rx_done held high for several cycles: each high cycle counts as a byte. The receiver guarantees single-cycle pulses.

Test Plan (bench instantiates the real ALU; tx_done model responds 5 cycles after each start):
- ADD: rx 05 00 00 00, 03 00 00 00, 20 → tx bytes 08 00 00 00; o_alu_op=6'h20; first o_tx_start 2 cycles after op byte.
- SUB negative: A=3, B=5, op 22 → tx FE FF FF FF; o_busy high from EXEC until the 4th i_tx_done.
- SRA: A=0x80000000 (00 00 00 80), B=4, op 03 → result 0xF8000000 → tx 00 00 00 F8. SRL op 02 with same operands → tx 00 00 00 08.
- Op byte upper bits: op byte E4 → o_alu_op=6'h24 (AND); A=0xFF00FF00, B=0x0FF00FF0 → tx 00 0F 00 0F.
- Busy drop: inject rx byte AA during TX_WAIT → ignored; the next frame ADD 1+1 returns 02 00 00 00 (no misalignment).
- Reset mid-frame: send 5 bytes of A/B, assert i_reset 1 cycle → outputs 0, state RX_A; then full frame XOR A=0xFFFFFFFF, B=0x0000FFFF, op 26 → tx 00 00 FF FF. Repeat with reset during TX_WAIT → no further o_tx_start.
